// File: rtl/baud_gen.sv
// Baud-rate tick generator: divides clk down to a one-cycle baud_en strobe
// every EN cycles while i_run is high.
module baud_gen #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int EN       = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic baud_en
);

  localparam int CW = $clog2(EN);
  localparam logic [CW-1:0] LAST = CW'(EN - 1);

  if (EN < 2 || CLK_FREQ <= 0 || BAUD <= 0) begin : g_bad_param
    $error("baud_gen: EN must be >= 2 and CLK_FREQ/BAUD positive");
  end

  logic [CW-1:0] cnt;

  // Dropping i_run wins over a pending terminal count, so no late tick escapes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      baud_en <= 1'b0;
    end else if (!i_run) begin
      cnt     <= '0;
      baud_en <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      baud_en <= 1'b1;
    end else begin
      cnt     <= cnt + 1'b1;
      baud_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_baud_gen.sv
// Randomized bench for baud_gen: four divider sizes checked against a
// run-length model (tick whenever the current run length is a multiple of EN).
module tb_baud_gen;

  localparam int N = 4;
  localparam int ENS [N] = '{868, 4, 2, 7};

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] run;
  logic [N-1:0] baud_en;

  int vectors = 0;
  int errors  = 0;
  int run_len [N];

  always #5 clk = ~clk;

  baud_gen #(.EN(868)) u_en868 (.clk(clk), .rst(rst_n), .i_run(run[0]), .baud_en(baud_en[0]));
  baud_gen #(.EN(4))   u_en4   (.clk(clk), .rst(rst_n), .i_run(run[1]), .baud_en(baud_en[1]));
  baud_gen #(.EN(2))   u_en2   (.clk(clk), .rst(rst_n), .i_run(run[2]), .baud_en(baud_en[2]));
  baud_gen #(.EN(7))   u_en7   (.clk(clk), .rst(rst_n), .i_run(run[3]), .baud_en(baud_en[3]));

  // Reference: count consecutive edges that sampled i_run high.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < N; i++) begin
      if (!rst_n)      run_len[i] <= 0;
      else if (run[i]) run_len[i] <= run_len[i] + 1;
      else             run_len[i] <= 0;
    end
  end

  function automatic logic model_tick(input int idx);
    return (run_len[idx] != 0) && (run_len[idx] % ENS[idx] == 0);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: baud_en=%b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  bit checking = 1'b0;
  always @(negedge clk) begin
    if (checking) begin
      for (int i = 0; i < N; i++)
        chk($sformatf("tick_en%0d", ENS[i]), baud_en[i], model_tick(i));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    run   = '0;
    #2;
    // Reset takes effect with no clock edge yet.
    for (int i = 0; i < N; i++) chk("reset_no_clk", baud_en[i], 1'b0);
    checking = 1'b1;
    cycles(2);
    rst_n = 1'b1;

    // Idle for 5000 ns: no ticks at all.
    cycles(500);

    // Basic run on all dividers; EN=868 ticks twice within 2000 cycles.
    cycles(3);
    run = '1;
    cycles(2000);

    // EN=4 stop after 2 counts, low 3 cycles, then restart.
    run = '0;
    cycles(2);
    run[1] = 1'b1;
    cycles(2);
    run[1] = 1'b0;
    cycles(3);
    run[1] = 1'b1;
    cycles(10);

    // EN=4 drop i_run on the edge where the terminal count would tick.
    begin
      int guard = 0;
      while (run_len[1] % 4 != 3 && guard < 20) begin
        cycles(1);
        guard++;
      end
      chk("sim_wait_bound", 1'(guard < 20), 1'b1);
      run[1] = 1'b0;
      cycles(1);
      chk("sim_drop_no_tick", baud_en[1], 1'b0);
      run[1] = 1'b1;
      cycles(10);
    end

    // Async reset while a tick is high: must clear before the next edge.
    begin
      int guard = 0;
      while (!(baud_en[1] === 1'b1) && guard < 20) begin
        cycles(1);
        guard++;
      end
      chk("async_wait_bound", 1'(guard < 20), 1'b1);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < N; i++) chk("async_rst_clear", baud_en[i], 1'b0);
      cycles(1);
      rst_n = 1'b1;
      cycles(12);
    end

    // Async reset mid-count (EN=4, cnt=2), release with i_run still high.
    begin
      int guard = 0;
      while (run_len[1] % 4 != 2 && guard < 20) begin
        cycles(1);
        guard++;
      end
      #2 rst_n = 1'b0;
      #1 chk("async_midcount", baud_en[1], 1'b0);
      cycles(1);
      rst_n = 1'b1;
      cycles(3);
      chk("post_rst_quiet", baud_en[1], 1'b0);
      cycles(1);
      chk("post_rst_first", baud_en[1], 1'b1);
    end

    // Randomized run toggling with occasional async resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 23) == 0) run[i] = ~run[i];
      if ($urandom_range(0, 299) == 0) begin
        #($urandom_range(1, 4)) rst_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) chk("rand_async_rst", baud_en[i], 1'b0);
        cycles(1);
        rst_n = 1'b1;
      end else begin
        cycles(1);
      end
    end

    // Long uninterrupted run so EN=868 keeps its period.
    run = '1;
    cycles(2700);

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
